// File: rtl/position_pkg.sv
// Shared constants and helpers for the board position tracker and the legacy display path.
package position_pkg;

  localparam int unsigned HOME_CODE = 0;
  localparam logic STEP_HOME  = 1'b0;
  localparam logic STEP_FRONT = 1'b1;

  localparam int unsigned MAX_POS = 64;

  // Home occupies the MSB, front the LSB; out-of-range codes yield all zeros.
  function automatic logic [MAX_POS-1:0] code_to_onehot(input int unsigned code,
                                                         input int unsigned num_pos);
    logic [MAX_POS-1:0] oh;
    oh = '0;
    if ((num_pos <= MAX_POS) && (code < num_pos)) begin
      oh = MAX_POS'(1) << (num_pos - 1 - code);
    end
    return oh;
  endfunction

endpackage

// File: rtl/position_tracker_if.sv
// Request/status bundle between the player-control FSM and the position tracker.
// Carries move_cnt only when POSITION_TRACKER_MOVE_CNT_EN is defined.
interface position_tracker_if #(
  parameter int unsigned NUM_POS = 3
);
  localparam int unsigned PW = $clog2(NUM_POS);

  logic               load_valid;
  logic [PW-1:0]      load_pos;
  logic               step_valid;
  logic               step_dir;
  logic               err_clr;
  logic [PW-1:0]      pos_code;
  logic [NUM_POS-1:0] pos_onehot;
  logic               at_home;
  logic               at_front;
  logic               bump;
  logic               moved;
  logic               err;
`ifdef POSITION_TRACKER_MOVE_CNT_EN
  logic [15:0]        move_cnt;
`endif

  modport master (
    output load_valid, load_pos, step_valid, step_dir, err_clr,
    input  pos_code, pos_onehot, at_home, at_front, bump, moved, err
`ifdef POSITION_TRACKER_MOVE_CNT_EN
    , input move_cnt
`endif
  );

  modport slave (
    input  load_valid, load_pos, step_valid, step_dir, err_clr,
    output pos_code, pos_onehot, at_home, at_front, bump, moved, err
`ifdef POSITION_TRACKER_MOVE_CNT_EN
    , output move_cnt
`endif
  );

endinterface

// File: rtl/position_next.sv
// Combinational next-position calculator: load beats step, steps saturate or wrap at the ends.
module position_next
  import position_pkg::*;
#(
  parameter int unsigned NUM_POS = 3,
  parameter int unsigned WRAP    = 0,
  localparam int unsigned PW     = $clog2(NUM_POS)
) (
  input  logic [PW-1:0] cur_code,
  input  logic          load_valid,
  input  logic [PW-1:0] load_pos,
  input  logic          step_valid,
  input  logic          step_dir,
  output logic [PW-1:0] next_code_c,
  output logic          bump_c,
  output logic          moved_c,
  output logic          load_err_c
);

  localparam int unsigned WW = PW + 1;
  localparam logic [WW-1:0] NUM_W   = WW'(NUM_POS);
  localparam logic [PW-1:0] FRONT_C = PW'(NUM_POS - 1);
  localparam logic [PW-1:0] HOME_C  = PW'(HOME_CODE);

  logic [WW-1:0] cur_w;
  logic [WW-1:0] load_w;
  logic [WW-1:0] inc_w;
  logic [WW-1:0] dec_w;

  // Extra bit keeps the end-of-board checks honest when NUM_POS is a power of two.
  always_comb begin
    cur_w  = {1'b0, cur_code};
    load_w = {1'b0, load_pos};
    inc_w  = cur_w + WW'(1);
    dec_w  = cur_w - WW'(1);
  end

  always_comb begin
    next_code_c = cur_code;
    bump_c      = 1'b0;
    moved_c     = 1'b0;
    load_err_c  = 1'b0;

    if (load_valid) begin
      if (load_w >= NUM_W) begin
        load_err_c = 1'b1;
      end else begin
        next_code_c = load_pos;
        moved_c     = (load_pos != cur_code);
      end
    end else if (step_valid) begin
      if (step_dir == STEP_FRONT) begin
        if (inc_w >= NUM_W) begin
          if (WRAP != 0) begin
            next_code_c = HOME_C;
            moved_c     = 1'b1;
          end else begin
            bump_c = 1'b1;
          end
        end else begin
          next_code_c = inc_w[PW-1:0];
          moved_c     = 1'b1;
        end
      end else begin
        // Borrow out of the top bit means we were already at home.
        if (dec_w[PW]) begin
          if (WRAP != 0) begin
            next_code_c = FRONT_C;
            moved_c     = 1'b1;
          end else begin
            bump_c = 1'b1;
          end
        end else begin
          next_code_c = dec_w[PW-1:0];
          moved_c     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/position_tracker.sv
// Registered board position tracker (code + one-hot, boundary bump, sticky load error).
// Define POSITION_TRACKER_MOVE_CNT_EN to add a saturating 16-bit move counter.
module position_tracker
  import position_pkg::*;
#(
  parameter int unsigned NUM_POS = 3,
  parameter int unsigned WRAP    = 0
) (
  input logic              clk,
  input logic              rst,
  position_tracker_if.slave bus
);

  localparam int unsigned PW = $clog2(NUM_POS);
  localparam logic [PW-1:0]      HOME_C    = PW'(HOME_CODE);
  localparam logic [PW-1:0]      FRONT_C   = PW'(NUM_POS - 1);
  localparam logic [NUM_POS-1:0] HOME_OH   = NUM_POS'(code_to_onehot(HOME_CODE, NUM_POS));

  logic [PW-1:0]      next_code_c;
  logic               bump_c;
  logic               moved_c;
  logic               load_err_c;

  logic [PW-1:0]      pos_code_q;
  logic [NUM_POS-1:0] pos_onehot_q;
  logic               at_home_q;
  logic               at_front_q;
  logic               bump_q;
  logic               moved_q;
  logic               err_q;

  position_next #(
    .NUM_POS (NUM_POS),
    .WRAP    (WRAP)
  ) u_next (
    .cur_code    (pos_code_q),
    .load_valid  (bus.load_valid),
    .load_pos    (bus.load_pos),
    .step_valid  (bus.step_valid),
    .step_dir    (bus.step_dir),
    .next_code_c (next_code_c),
    .bump_c      (bump_c),
    .moved_c     (moved_c),
    .load_err_c  (load_err_c)
  );

  // Flags are derived from the next code so they line up with pos_code.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_code_q   <= HOME_C;
      pos_onehot_q <= HOME_OH;
      at_home_q    <= 1'b1;
      at_front_q   <= 1'b0;
      bump_q       <= 1'b0;
      moved_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      pos_code_q   <= next_code_c;
      pos_onehot_q <= NUM_POS'(code_to_onehot(32'(next_code_c), NUM_POS));
      at_home_q    <= (next_code_c == HOME_C);
      at_front_q   <= (next_code_c == FRONT_C);
      bump_q       <= bump_c;
      moved_q      <= moved_c;
      if (load_err_c) begin
        err_q <= 1'b1;
      end else if (bus.err_clr) begin
        err_q <= 1'b0;
      end
    end
  end

  assign bus.pos_code   = pos_code_q;
  assign bus.pos_onehot = pos_onehot_q;
  assign bus.at_home    = at_home_q;
  assign bus.at_front   = at_front_q;
  assign bus.bump       = bump_q;
  assign bus.moved      = moved_q;
  assign bus.err        = err_q;

`ifdef POSITION_TRACKER_MOVE_CNT_EN
  logic [15:0] move_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      move_cnt_q <= 16'd0;
    end else if (moved_c && (move_cnt_q != 16'hFFFF)) begin
      move_cnt_q <= move_cnt_q + 16'd1;
    end
  end

  assign bus.move_cnt = move_cnt_q;
`endif

endmodule
